// File: rtl/mult_8_bit_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : mult_8_bit_seq_if                                          |
// | Brief   : Request/result and mult_4_bit bus for mult_8_bit_seq.      |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
interface mult_8_bit_seq_if;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [3:0]  in1;
  logic [3:0]  in2;
  logic [7:0]  mult_out;
  logic [1:0]  phase;
  logic        busy;
  logic        done;
  logic [15:0] out;

  modport slave (
    input  start, a, b, mult_out,
    output in1, in2, phase, busy, done, out
  );

  modport master (
    output start, a, b, mult_out,
    input  in1, in2, phase, busy, done, out
  );
endinterface
`default_nettype wire

// File: rtl/mult_8_bit_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : mult_8_bit_seq                                             |
// | Brief   : Request-driven 8x8 multiply sequencer over one 4x4 unit.   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module mult_8_bit_seq (
  input  wire logic        clk,
  input  wire logic        rst,
  mult_8_bit_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [7:0]  ra_q,    ra_d;
  logic [7:0]  rb_q,    rb_d;
  logic [15:0] acc_q,   acc_d;
  logic [15:0] out_q,   out_d;

  logic [3:0]  w_in1;
  logic [3:0]  w_in2;
  logic [15:0] w_prod;
  logic [15:0] w_term;
  logic [15:0] w_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      phase_q <= 2'd0;
      ra_q    <= 8'd0;
      rb_q    <= 8'd0;
      acc_q   <= 16'd0;
      out_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
    end
  end

  // Nibble select and partial-product weighting decoded from registered state,
  // so in1/in2 only move on clock edges.
  always_comb begin
    w_in1  = 4'd0;
    w_in2  = 4'd0;
    w_prod = {8'd0, bus.mult_out};
    w_term = 16'd0;
    if (state_q == S_CALC) begin
      case (phase_q)
        2'd0: begin w_in1 = ra_q[3:0]; w_in2 = rb_q[3:0]; w_term = w_prod;      end
        2'd1: begin w_in1 = ra_q[3:0]; w_in2 = rb_q[7:4]; w_term = w_prod << 4; end
        2'd2: begin w_in1 = ra_q[7:4]; w_in2 = rb_q[3:0]; w_term = w_prod << 4; end
        default: begin w_in1 = ra_q[7:4]; w_in2 = rb_q[7:4]; w_term = w_prod << 8; end
      endcase
    end
    w_sum = acc_q + w_term;
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    acc_d   = acc_q;
    out_d   = out_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          ra_d    = bus.a;
          rb_d    = bus.b;
          acc_d   = 16'd0;
          phase_d = 2'd0;
          state_d = S_CALC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        acc_d   = w_sum;
        phase_d = phase_q + 2'd1;
        // The final load takes the sum including the phase-3 term.
        if (phase_q == 2'd3) begin
          out_d   = w_sum;
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        phase_d = 2'd0;
      end
    endcase
  end

  assign bus.in1   = w_in1;
  assign bus.in2   = w_in2;
  assign bus.phase = phase_q;
  assign bus.busy  = (state_q == S_CALC);
  assign bus.done  = (state_q == S_DONE);
  assign bus.out   = out_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_8_bit_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_mult_8_bit_seq                                          |
// | Brief   : Self-checking bench for mult_8_bit_seq against a*b model.  |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_mult_8_bit_seq;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [15:0] held;

  mult_8_bit_seq_if bus();

  mult_8_bit_seq u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural stand-in for the external 4x4 multiplier.
  assign bus.mult_out = {4'd0, bus.in1} * {4'd0, bus.in2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request from IDLE/DONE and follow it to its DONE cycle.
  task automatic do_op(input logic [7:0] x, input logic [7:0] y, input bit hold, input string tag);
    logic [15:0] e;
    e = 16'(x) * 16'(y);
    bus.a     = x;
    bus.b     = y;
    bus.start = 1'b1;
    step();
    if (!hold) bus.start = 1'b0;
    bus.a = 8'($urandom);
    bus.b = 8'($urandom);
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_busy"},  32'(bus.busy),  32'd1);
      chk({tag, "_phase"}, 32'(bus.phase), 32'(k));
      chk({tag, "_nodone"}, 32'(bus.done), 32'd0);
      chk({tag, "_hold"},  32'(bus.out),   32'(held));
      step();
    end
    chk({tag, "_done"},  32'(bus.done),  32'd1);
    chk({tag, "_dbusy"}, 32'(bus.busy),  32'd0);
    chk({tag, "_dph"},   32'(bus.phase), 32'd0);
    chk({tag, "_out"},   32'(bus.out),   32'(e));
    held = e;
  endtask

  initial begin
    int dones;
    n_checks  = 0;
    n_fail    = 0;
    held      = 16'd0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = 8'd0;
    bus.b     = 8'd0;
    step();
    step();
    rst = 1'b0;
    chk("rst_out",   32'(bus.out),   32'd0);
    chk("rst_busy",  32'(bus.busy),  32'd0);
    chk("rst_done",  32'(bus.done),  32'd0);
    chk("rst_phase", 32'(bus.phase), 32'd0);
    chk("rst_in1",   32'(bus.in1),   32'd0);
    chk("rst_in2",   32'(bus.in2),   32'd0);

    do_op(8'h0F, 8'h0F, 1'b0, "op0f");
    chk("op0f_val", 32'(bus.out), 32'h00E1);
    step();
    chk("op0f_idle_done", 32'(bus.done), 32'd0);
    chk("op0f_idle_busy", 32'(bus.busy), 32'd0);
    chk("op0f_idle_in1",  32'(bus.in1),  32'd0);

    do_op(8'hFF, 8'hFF, 1'b0, "opff");
    chk("opff_val", 32'(bus.out), 32'hFE01);
    step();
    do_op(8'h00, 8'hA5, 1'b0, "opzero");
    step();

    // Mid-CALC start with new operands must be ignored.
    dones     = 0;
    bus.a     = 8'h12;
    bus.b     = 8'h34;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (k == 1) begin
        bus.a     = 8'hFF;
        bus.b     = 8'hFF;
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        dones++;
        chk("midstart_out", 32'(bus.out), 32'h03A8);
      end
      step();
    end
    chk("midstart_ndone", 32'(dones), 32'd1);
    held = 16'h03A8;

    do_op(8'h10, 8'h10, 1'b1, "b2b0");
    chk("b2b0_val", 32'(bus.out), 32'h0100);
    do_op(8'h80, 8'h02, 1'b1, "b2b1");
    chk("b2b1_val", 32'(bus.out), 32'h0100);
    do_op(8'hAB, 8'hCD, 1'b1, "b2b2");
    chk("b2b2_val", 32'(bus.out), 32'h88EF);
    bus.start = 1'b0;
    step();

    // Reset in phase 2 discards the operation.
    bus.a     = 8'hFF;
    bus.b     = 8'hFF;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    chk("rstmid_phase", 32'(bus.phase), 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    held = 16'd0;
    chk("rstmid_out",  32'(bus.out),  32'd0);
    chk("rstmid_busy", 32'(bus.busy), 32'd0);
    chk("rstmid_done", 32'(bus.done), 32'd0);
    chk("rstmid_in1",  32'(bus.in1),  32'd0);
    chk("rstmid_in2",  32'(bus.in2),  32'd0);
    dones = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus.done) dones++;
      step();
    end
    chk("rstmid_nodone", 32'(dones), 32'd0);
    do_op(8'h03, 8'h05, 1'b0, "op35");
    chk("op35_val", 32'(bus.out), 32'h000F);
    step();

    for (int i = 0; i < 1000; i++) begin
      int gap;
      do_op(8'($urandom), 8'($urandom), 1'b0, "rnd");
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        step();
        chk("rnd_gap_done", 32'(bus.done), 32'd0);
        chk("rnd_gap_out",  32'(bus.out),  32'(held));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
